prog_loader: RTL

Hardware program loader for the SAP-1.5 computer. It accepts a framed byte stream over a valid/ready handshake and writes the bytes into program RAM through the RAM write port. While it loads, it holds the CPU in reset. Once it has validated a checksum, it releases the CPU. It is the in-system counterpart of the simulation-time memory preload: it writes the RAM image that the CPU later executes and that benches inspect.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Streams a framed program image into the SAP-1.5 program RAM while holding
//   the CPU in reset, then releases the CPU once the frame checksum is good.
//   Frame: ADDR byte, LEN byte, LEN data bytes, CSUM byte. The frame is good
//   when (sum of data bytes + CSUM) mod 2^DATA_WIDTH == 0.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid   stream byte present on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   ram_we     RAM write strobe, one cycle per data byte
//   ram_addr   RAM write address
//   ram_wdata  RAM write data
//   cpu_hold   CPU reset; high keeps the CPU in reset
//   done       last load completed with a good checksum
//   error      last load failed its checksum
module prog_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        DONE,
        ERR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] csum_total;
    logic                  xfer;

    assign xfer       = in_valid && in_ready;
    // Running data sum plus the checksum byte currently on the stream.
    assign csum_total = sum + in_data;

    // All outputs are registered alongside the state so that they change
    // together with it: in_ready is set on the edge that leaves a waiting
    // state, done/error/cpu_hold on the edge that accepts CSUM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless a data byte lands.
            ram_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= S_ADDR;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (xfer) begin
                        addr  <= in_data[ADDR_WIDTH-1:0];
                        sum   <= '0;
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        count <= in_data;
                        state <= (in_data == '0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= in_data;
                        sum       <= csum_total;
                        addr      <= addr + ADDR_WIDTH'(1);
                        count     <= count - DATA_WIDTH'(1);
                        if (count == DATA_WIDTH'(1)) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (csum_total == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
